// File: rtl/mem_byte_unit.sv
// Byte-serial load/store engine: moves 1/2/4/8 bytes little-endian over an 8-bit req/ack bus.
// Optional ack timeout abort is enabled with `define MEM_BYTE_UNIT_TIMEOUT_EN.
module mem_byte_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [63:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

  state_t              r_state;
  logic                r_we;
  logic [2:0]          r_k;
  logic [2:0]          r_last;
  logic [63:0]         r_wdata;
  logic [63:0]         r_rdata;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic [2:0]          w_last;

`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
`endif

  // Index of the final byte for each size code (1, 4, 8, 2 bytes).
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_last = 3'd0;
    case (size)
      2'b00:   w_last = 3'd0;
      2'b01:   w_last = 3'd3;
      2'b10:   w_last = 3'd7;
      default: w_last = 3'd1;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: rdata and the store shift register sit on the async reset too, so outputs are defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_k         <= 3'd0;
      r_last      <= 3'd0;
      r_wdata     <= 64'd0;
      r_rdata     <= 64'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
      r_wait      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_we        <= we;
            r_last      <= w_last;
            r_k         <= 3'd0;
            r_wdata     <= wdata;
            r_mem_addr  <= addr;
            r_mem_wdata <= wdata[7:0];
            r_mem_we    <= we;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            if (!we) r_rdata <= 64'd0;
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
            r_wait      <= '0;
`endif
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            if (!r_we) r_rdata[{r_k, 3'b000} +: 8] <= mem_rdata;
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
            r_wait <= '0;
`endif
            if (r_k == r_last) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_FIN;
            end else begin
              // Store data is a shift register so the next byte is always at [15:8].
              r_k         <= r_k + 3'd1;
              r_mem_addr  <= r_mem_addr + ADDR_W'(1);
              r_wdata     <= r_wdata >> 8;
              r_mem_wdata <= r_wdata[15:8];
            end
          end
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
          else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
`endif
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
`ifdef MEM_BYTE_UNIT_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule
